// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared opcode/state types for the sequential ALU
// Purpose: opcode and FSM state enumerations plus a small opcode helper.
// Ports: none (package).
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SAR = 3'b111
  } opc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Opcodes 110 and 111 are the iterative shifts.
  function automatic logic is_shift(input logic [2:0] opc);
    return opc[2] & opc[1];
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/result handshake bundle for the sequential ALU
// Purpose: groups the request side (in_*, opc) and result side (out_*, flags).
// Ports: master drives in_valid/opc/in_m/in_n/in_c/out_ready;
//        slave drives in_ready/out_valid/out_f/zer/neg/cout/ovf.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opc;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] in_n;
  logic             in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic             zer;
  logic             neg;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, opc, in_m, in_n, in_c, out_ready,
    input  in_ready, out_valid, out_f, zer, neg, cout, ovf
  );

  modport slave (
    input  in_valid, opc, in_m, in_n, in_c, out_ready,
    output in_ready, out_valid, out_f, zer, neg, cout, ovf
  );
endinterface

// File: rtl/seq_alu_core.sv
// rtl/seq_alu_core.sv - combinational single-cycle ALU ops with carry/overflow
// Purpose: module alu_core; evaluates opcodes 000-101 in one pass. Shift
//          opcodes pass M through unchanged (the shift-by-zero result).
// Ports: i_opc, i_m, i_n, i_c in; o_f result, o_cout, o_ovf out.
module alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       i_opc,
  input  logic [WIDTH-1:0] i_m,
  input  logic [WIDTH-1:0] i_n,
  input  logic             i_c,
  output logic [WIDTH-1:0] o_f,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;

  // One extra bit catches carry out of ADD and borrow (wrap) of SUB.
  assign w_sum = {1'b0, i_m} + {1'b0, i_n} + {{WIDTH{1'b0}}, i_c};
  assign w_dif = {1'b0, i_m} - {1'b0, i_n} - {{WIDTH{1'b0}}, i_c};

  always_comb begin
    o_f    = i_m;
    o_cout = 1'b0;
    o_ovf  = 1'b0;
    case (i_opc)
      OP_ADD: begin
        o_f    = w_sum[WIDTH-1:0];
        o_cout = w_sum[WIDTH];
        o_ovf  = (i_m[WIDTH-1] == i_n[WIDTH-1]) && (w_sum[WIDTH-1] != i_m[WIDTH-1]);
      end
      OP_SUB: begin
        o_f    = w_dif[WIDTH-1:0];
        o_cout = w_dif[WIDTH];
        o_ovf  = (i_m[WIDTH-1] != i_n[WIDTH-1]) && (w_dif[WIDTH-1] != i_m[WIDTH-1]);
      end
      OP_AND:         o_f = i_m & i_n;
      OP_OR:          o_f = i_m | i_n;
      OP_XOR:         o_f = i_m ^ i_n;
      OP_NOT:         o_f = ~i_m;
      OP_SHL, OP_SAR: o_f = i_m;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with iterative shifter and result hold
// Purpose: accepts one op per handshake, computes single-cycle ops via
//          alu_core, shifts one bit per cycle for SHL/SAR, holds the result
//          until the consumer takes it.
// Ports: clk, rst (sync, active-high); bus (seq_alu_if.slave) carrying the
//        request handshake, operands, result handshake, result and flags.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CARRY_CHAIN = 0
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);

  localparam int KW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_HOLD = ST_HOLD;

  logic [1:0]       r_state;
  logic [KW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic             r_sh_sar;
  logic [WIDTH-1:0] r_f;
  logic             r_zer;
  logic             r_neg;
  logic             r_cout;
  logic             r_ovf;
  logic             r_carry;

  logic             w_ready;
  logic             w_accept;
  logic [KW-1:0]    w_k;
  logic             w_c;
  logic             w_iter;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_out;
  logic [WIDTH-1:0] w_alu_f;
  logic             w_alu_cout;
  logic             w_alu_ovf;

  // In HOLD a new request is taken in the same cycle the result is consumed.
  assign w_ready   = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.out_ready);
  assign w_accept  = bus.in_valid && w_ready;
  assign w_k       = bus.in_n[KW-1:0];
  assign w_c       = (CARRY_CHAIN != 0) ? r_carry : bus.in_c;
  assign w_iter    = is_shift(bus.opc) && (w_k != '0);
  assign w_sh_next = r_sh_sar ? {r_sh[WIDTH-1], r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], 1'b0};
  assign w_sh_out  = r_sh_sar ? r_sh[0] : r_sh[WIDTH-1];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_opc  (bus.opc),
    .i_m    (bus.in_m),
    .i_n    (bus.in_n),
    .i_c    (w_c),
    .o_f    (w_alu_f),
    .o_cout (w_alu_cout),
    .o_ovf  (w_alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sh     <= '0;
      r_sh_sar <= 1'b0;
      r_f      <= '0;
      r_zer    <= 1'b0;
      r_neg    <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      if (w_iter) begin
        r_state  <= S_BUSY;
        r_sh     <= bus.in_m;
        r_sh_sar <= bus.opc[0];
        r_cnt    <= w_k;
      end else begin
        r_state <= S_HOLD;
        r_f     <= w_alu_f;
        r_zer   <= (w_alu_f == '0);
        r_neg   <= w_alu_f[WIDTH-1];
        r_cout  <= w_alu_cout;
        r_ovf   <= w_alu_ovf;
        if ((bus.opc == OP_ADD) || (bus.opc == OP_SUB)) r_carry <= w_alu_cout;
      end
    end else if (r_state == S_BUSY) begin
      r_sh  <= w_sh_next;
      r_cnt <= r_cnt - KW'(1);
      // The final shift lands directly in the result register.
      if (r_cnt == KW'(1)) begin
        r_state <= S_HOLD;
        r_f     <= w_sh_next;
        r_zer   <= (w_sh_next == '0);
        r_neg   <= w_sh_next[WIDTH-1];
        r_cout  <= w_sh_out;
        r_ovf   <= 1'b0;
      end
    end else if ((r_state == S_HOLD) && bus.out_ready) begin
      r_state <= S_IDLE;
    end else if (r_state == 2'b11) begin
      r_state <= S_IDLE;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.out_f     = r_f;
  assign bus.zer       = r_zer;
  assign bus.neg       = r_neg;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; legal range 4..64, power of two.
REQ-002 Parameter CARRY_CHAIN, default 0: 1 makes ADD/SUB use the internal carry register instead of in_c.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 opc  input  3  opcode (see REQ-012).
REQ-008 in_m, in_n  input  WIDTH  operands M, N.
REQ-009 in_c  input  1  carry/borrow in (ignored when CARRY_CHAIN=1).
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result; out_f  output  WIDTH  result; zer, neg, cout, ovf  output  1 each  flags.

Function
REQ-012 Opcodes: 000 ADD F=M+N+c; 001 SUB F=M-N-c; 010 AND; 011 OR; 100 XOR; 101 NOT M; 110 SHL M by k; 111 SAR (arithmetic right) M by k; k = in_n[log2(WIDTH)-1:0]; c = in_c, or carry register when CARRY_CHAIN=1.
REQ-013 Transfer occurs on an edge where in_valid and in_ready are both 1; operands and opcode captured at that edge.
REQ-014 States: IDLE, BUSY, HOLD; reset state IDLE.
REQ-015 IDLE: in_ready=1, out_valid=0; accept of opcodes 000-101, or of 110/111 with k=0, goes to HOLD with result registered (latency 1 cycle).
REQ-016 Accept of 110/111 with k>0 goes to BUSY; BUSY shifts one bit per cycle for exactly k cycles, then enters HOLD (out_valid on edge k+1 after accept); in_ready=0 in BUSY.
REQ-017 HOLD: out_valid=1; out_f and flags stable while out_ready=0; in_ready = out_ready.
REQ-018 HOLD with out_ready=1 and no new transfer goes to IDLE; with simultaneous transfer, the new op is accepted same cycle (back-to-back, no bubble) and next state follows REQ-015/016.
REQ-019 zer = (out_f==0); neg = out_f[WIDTH-1].
REQ-020 cout: ADD carry out of MSB; SUB 1 when borrow occurs; SHL/SAR last bit shifted out (0 when k=0); logic ops 0.
REQ-021 ovf: signed two's-complement overflow for ADD/SUB; 0 for all other ops.
REQ-022 Carry register loaded with cout only when an ADD or SUB result enters HOLD; unchanged by other ops.
REQ-023 Arithmetic performed at WIDTH+1 bits; out_f is the low WIDTH bits (wrap-around).
REQ-024 in_valid while in_ready=0 is ignored; requester must hold it (no internal queue).

Reset
REQ-025 rst=1 at an edge forces IDLE, out_valid=0, out_f=0, zer=0, neg=0, cout=0, ovf=0, carry register=0, shift counter=0.
REQ-026 Reset in BUSY or HOLD aborts the operation; no result is produced; in_ready=1 in the cycle after reset deasserts.
REQ-027 No transfer accepted on an edge where rst=1.

Structure
REQ-028 Package seq_alu_pkg holds opcode enum (ADD..SAR) and state enum (IDLE, BUSY, HOLD).
REQ-029 Sub-module alu_core: purely combinational single-cycle ops (000-101) plus flag generation, parametrised by WIDTH; iterative shifter and FSM stay in seq_alu.

Verification (WIDTH=16)
REQ-030 ADD M=0x7FFF N=0x0001 c=0 -> next cycle out_valid=1, F=0x8000, neg=1, ovf=1, cout=0, zer=0.
REQ-031 SUB M=0x0005 N=0x0005 c=0 -> F=0x0000, zer=1, cout=0, ovf=0; SUB M=0x0000 N=0x0001 -> F=0xFFFF, cout=1, neg=1.
REQ-032 SHL M=0x8001 N=0x0004 -> in_ready=0 for 4 cycles, out_valid on 5th edge, F=0x0010, cout=0; SAR M=0x8000 N=0x000F -> F=0xFFFF, cout=0.
REQ-033 Hold out_ready=0 for 3 cycles in HOLD -> out_f/flags stable, in_ready=0; raise out_ready with in_valid=1 -> new op accepted that edge, next result one cycle later.
REQ-034 CARRY_CHAIN=1: ADD 0xFFFF+0x0001 -> F=0x0000, cout=1; then ADD 0x0000+0x0000 in_c=0 -> F=0x0001; AND op between them leaves carry register at 1.
REQ-035 Assert rst during BUSY of SHL k=8 -> out_valid=0, all outputs 0, in_ready=1 after rst deasserts; no stale result appears.
